mac_result_collector: RTL and testbench

MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

---
 rtl/mac_result_collector_pkg.sv | 16 +
 rtl/mac_result_collector_fifo.sv | 77 +++++++
 rtl/mac_result_collector.sv | 109 ++++++++++
 tb/tb_mac_result_collector.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_result_collector_pkg.sv
// Shared types and sizing for the MAC result collector.
// Imported by the collector top and its output FIFO.
package AcceleratorPackage;

  localparam int ResultFifoDepth = 8;
  localparam int AccumGuardBits  = 8;

  typedef logic signed [31:0] AcclDataType;

  typedef enum logic [1:0] {
    s_Idle,
    s_Accum,
    s_Emit
  } CollectorStateType;

endpackage

// File: rtl/mac_result_collector_fifo.sv
// Synchronous result FIFO: one write port, one registered read port.
// A push into a full FIFO is dropped unless a pop frees a slot that cycle.
module result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               pop_data_o,
  output logic                       pop_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          ovf_q;

  logic do_pop_w;
  logic do_push_w;
  logic full_w;

  assign full_w    = (count_q == CW'(DEPTH));
  assign do_pop_w  = pop_i && (count_q != '0);
  assign do_push_w = push_i && (!full_w || do_pop_w);

  always_ff @(posedge clk_i) begin
    if (do_push_w) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= do_pop_w;
      if (do_push_w) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop_w) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push_w, do_pop_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_i && !do_push_w) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign pop_data_o  = data_q;
  assign pop_valid_o = valid_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/mac_result_collector.sv
// Accumulates groups of partial MAC results, saturates and optionally
// applies ReLU, then queues each final value for bus reads.
module mac_result_collector
  import AcceleratorPackage::*;
#(
  parameter int DATA_W     = $bits(AcclDataType),
  parameter int ACC_W      = DATA_W + AccumGuardBits,
  parameter int FIFO_DEPTH = ResultFifoDepth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ClearIn,
  input  logic                          ResultValidIn,
  input  logic [DATA_W-1:0]             ResultIn,
  input  logic [3:0]                    AccumLenIn,
  input  logic                          ReluEnIn,
  input  logic                          ReadEnIn,
  output logic [DATA_W-1:0]             DataOut,
  output logic                          DataValidOut,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCountOut,
  output logic                          StallOut,
  output logic                          OverflowOut
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  CollectorStateType        state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [4:0]               len_q;
  logic [4:0]               beat_q;

  logic                     clr_w;
  logic [ACC_W-1:0]         res_ext_w;
  logic [4:0]               len_w;
  logic [ACC_W-DATA_W:0]    hi_w;
  logic [DATA_W-1:0]        sat_w;
  logic [DATA_W-1:0]        final_w;
  logic                     push_w;

  assign clr_w     = reset || ClearIn;
  assign res_ext_w = {{(ACC_W-DATA_W){ResultIn[DATA_W-1]}}, ResultIn};
  assign len_w     = (AccumLenIn == 4'd0) ? 5'd16 : {1'b0, AccumLenIn};

  always_ff @(posedge clk) begin
    if (clr_w) begin
      state_q <= s_Idle;
      acc_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        s_Accum: begin
          if (ResultValidIn) begin
            acc_q  <= acc_q + res_ext_w;
            beat_q <= beat_q + 5'd1;
            if (beat_q + 5'd1 == len_q) begin
              state_q <= s_Emit;
            end
          end
        end
        s_Idle, s_Emit: begin
          // A beat during emit opens the next group without a bubble.
          if (ResultValidIn) begin
            acc_q   <= res_ext_w;
            len_q   <= len_w;
            beat_q  <= 5'd1;
            state_q <= (len_w == 5'd1) ? s_Emit : s_Accum;
          end else begin
            state_q <= s_Idle;
          end
        end
        default: state_q <= s_Idle;
      endcase
    end
  end

  assign hi_w = acc_q[ACC_W-1:DATA_W-1];

  always_comb begin
    sat_w = acc_q[DATA_W-1:0];
    if (!((&hi_w) || !(|hi_w))) begin
      sat_w = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign final_w = (ReluEnIn && sat_w[DATA_W-1]) ? '0 : sat_w;
  assign push_w  = (state_q == s_Emit);

  assign StallOut =
    (FifoCountOut >= CW'(FIFO_DEPTH - 1)) ||
    ((FifoCountOut == CW'(FIFO_DEPTH - 2)) && push_w);

  result_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .clr_i       (clr_w),
    .push_i      (push_w),
    .push_data_i (final_w),
    .pop_i       (ReadEnIn),
    .pop_data_o  (DataOut),
    .pop_valid_o (DataValidOut),
    .count_o     (FifoCountOut),
    .overflow_o  (OverflowOut)
  );

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: directed scenarios
// plus randomized groups scored against an arithmetic reference model.
module tb_mac_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        ClearIn;
  logic        ResultValidIn;
  logic [31:0] ResultIn;
  logic [3:0]  AccumLenIn;
  logic        ReluEnIn;
  logic        ReadEnIn;
  logic [31:0] DataOut;
  logic        DataValidOut;
  logic [3:0]  FifoCountOut;
  logic        StallOut;
  logic        OverflowOut;

  int checks = 0;
  int passed = 0;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mac_result_collector dut (
    .clk           (clk),
    .reset         (reset),
    .ClearIn       (ClearIn),
    .ResultValidIn (ResultValidIn),
    .ResultIn      (ResultIn),
    .AccumLenIn    (AccumLenIn),
    .ReluEnIn      (ReluEnIn),
    .ReadEnIn      (ReadEnIn),
    .DataOut       (DataOut),
    .DataValidOut  (DataValidOut),
    .FifoCountOut  (FifoCountOut),
    .StallOut      (StallOut),
    .OverflowOut   (OverflowOut)
  );

  function automatic logic [31:0] model(input longint sum, input bit relu);
    longint r;
    r = sum;
    if (r > SMAX) r = SMAX;
    else if (r < SMIN) r = SMIN;
    if (relu && r < 0) r = 0;
    return r[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ClearIn = 1'b0;
    ResultValidIn = 1'b1;
    ResultIn = 32'h0001_0000;
    AccumLenIn = 4'd1;
    ReadEnIn = 1'b0;
    step();
    reset = 1'b0;
    ResultValidIn = 1'b0;
  endtask

  task automatic beat(input logic [31:0] v, input logic [3:0] len);
    ResultValidIn = 1'b1;
    ResultIn = v;
    AccumLenIn = len;
    step();
    ResultValidIn = 1'b0;
  endtask

  task automatic read_one();
    ReadEnIn = 1'b1;
    step();
    ReadEnIn = 1'b0;
  endtask

  task automatic test_reset();
    ReluEnIn = 1'b0;
    do_reset();
    step();
    checks++;
    if (FifoCountOut !== 4'd0)
      $display("FAIL reset_count got %0d want 0", FifoCountOut);
    else passed++;
    checks++;
    if ({DataValidOut, OverflowOut, StallOut} !== 3'b000)
      $display("FAIL reset_flags got %b want 000",
               {DataValidOut, OverflowOut, StallOut});
    else passed++;
    checks++;
    if (DataOut !== 32'h0)
      $display("FAIL reset_data got %h want 0", DataOut);
    else passed++;
  endtask

  task automatic test_sum4();
    do_reset();
    ReluEnIn = 1'b0;
    for (int i = 1; i <= 4; i++) beat(32'(i) << 16, 4'd4);
    checks++;
    if (FifoCountOut !== 4'd0)
      $display("FAIL sum4_early got %0d want 0", FifoCountOut);
    else passed++;
    step();
    checks++;
    if (FifoCountOut !== 4'd1)
      $display("FAIL sum4_count got %0d want 1", FifoCountOut);
    else passed++;
    read_one();
    checks++;
    if (DataValidOut !== 1'b1 || DataOut !== 32'h000A_0000)
      $display("FAIL sum4_read got %b/%h want 1/000a0000",
               DataValidOut, DataOut);
    else passed++;
    step();
    checks++;
    if (DataValidOut !== 1'b0 || DataOut !== 32'h000A_0000)
      $display("FAIL sum4_hold got %b/%h want 0/000a0000",
               DataValidOut, DataOut);
    else passed++;
    read_one();
    checks++;
    if (DataValidOut !== 1'b0 || FifoCountOut !== 4'd0)
      $display("FAIL empty_read got %b/%0d want 0/0",
               DataValidOut, FifoCountOut);
    else passed++;
  endtask

  task automatic test_relu();
    logic [31:0] want [2];
    want[0] = 32'h0000_0000;
    want[1] = 32'hFFFD_0000;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      ReluEnIn = (r == 0);
      beat(32'hFFFB_0000, 4'd2);
      beat(32'h0002_0000, 4'd2);
      step();
      read_one();
      checks++;
      if (DataValidOut !== 1'b1 || DataOut !== want[r])
        $display("FAIL relu%0d got %b/%h want 1/%h",
                 r, DataValidOut, DataOut, want[r]);
      else passed++;
    end
    ReluEnIn = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] v [2];
    v[0] = 32'h7FFF_FFFF;
    v[1] = 32'h8000_0000;
    do_reset();
    ReluEnIn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat(v[k], 4'd2);
      beat(v[k], 4'd2);
      step();
      read_one();
      checks++;
      if (DataOut !== v[k])
        $display("FAIL sat%0d got %h want %h", k, DataOut, v[k]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ReluEnIn = 1'b0;
    for (int i = 0; i < 9; i++) begin
      beat(32'd100 + 32'(i), 4'd1);
      if (i == 5) begin
        checks++;
        if (FifoCountOut !== 4'd5 || StallOut !== 1'b0)
          $display("FAIL stall_c5 got %0d/%b want 5/0",
                   FifoCountOut, StallOut);
        else passed++;
      end
      if (i == 6) begin
        checks++;
        if (FifoCountOut !== 4'd6 || StallOut !== 1'b1)
          $display("FAIL stall_c6_emit got %0d/%b want 6/1",
                   FifoCountOut, StallOut);
        else passed++;
      end
    end
    step();
    checks++;
    if (FifoCountOut !== 4'd8 || OverflowOut !== 1'b1 || StallOut !== 1'b1)
      $display("FAIL ovf_full got %0d/%b/%b want 8/1/1",
               FifoCountOut, OverflowOut, StallOut);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      read_one();
      checks++;
      if (DataOut !== 32'd100 + 32'(i) || DataValidOut !== 1'b1)
        $display("FAIL ovf_read%0d got %b/%h want 1/%h",
                 i, DataValidOut, DataOut, 32'd100 + 32'(i));
      else passed++;
      if (i == 0) begin
        checks++;
        if (StallOut !== 1'b1)
          $display("FAIL stall_c7 got %b want 1", StallOut);
        else passed++;
      end
      if (i == 1) begin
        checks++;
        if (StallOut !== 1'b0)
          $display("FAIL stall_c6_idle got %b want 0", StallOut);
        else passed++;
      end
    end
    checks++;
    if (OverflowOut !== 1'b1 || FifoCountOut !== 4'd0)
      $display("FAIL ovf_sticky got %b/%0d want 1/0",
               OverflowOut, FifoCountOut);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ReluEnIn = 1'b0;
    for (int i = 0; i < 8; i++) beat(32'd200 + 32'(i), 4'd1);
    beat(32'd300, 4'd1);
    ReadEnIn = 1'b1;
    step();
    ReadEnIn = 1'b0;
    checks++;
    if (FifoCountOut !== 4'd8 || OverflowOut !== 1'b0)
      $display("FAIL fullpp_count got %0d/%b want 8/0",
               FifoCountOut, OverflowOut);
    else passed++;
    checks++;
    if (DataOut !== 32'd200 || DataValidOut !== 1'b1)
      $display("FAIL fullpp_data got %b/%h want 1/%h",
               DataValidOut, DataOut, 32'd200);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] w;
      w = (i == 8) ? 32'd300 : 32'd200 + 32'(i);
      read_one();
      checks++;
      if (DataOut !== w)
        $display("FAIL fullpp_drain%0d got %h want %h", i, DataOut, w);
      else passed++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    ReluEnIn = 1'b0;
    beat(32'h0001_0000, 4'd4);
    beat(32'h0001_0000, 4'd4);
    ClearIn = 1'b1;
    beat(32'h0001_0000, 4'd4);
    ClearIn = 1'b0;
    checks++;
    if (FifoCountOut !== 4'd0 || OverflowOut !== 1'b0)
      $display("FAIL clear_state got %0d/%b want 0/0",
               FifoCountOut, OverflowOut);
    else passed++;
    for (int i = 0; i < 4; i++) beat(32'h0001_0000, 4'd4);
    step();
    read_one();
    checks++;
    if (DataOut !== 32'h0004_0000)
      $display("FAIL clear_sum got %h want 00040000", DataOut);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int len;
    longint sum;
    logic [31:0] v;
    do_reset();
    ReluEnIn = 1'b0;
    for (int g = 0; g < 5; g++) begin
      len = $urandom_range(1, 4);
      sum = 0;
      for (int i = 0; i < len; i++) begin
        v = $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
        sum += longint'(signed'(v));
        beat(v, (i == 0) ? 4'(len) : 4'($urandom_range(0, 15)));
      end
      exp_q.push_back(model(sum, 1'b0));
    end
    step();
    checks++;
    if (FifoCountOut !== 4'd5)
      $display("FAIL b2b_count got %0d want 5", FifoCountOut);
    else passed++;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = exp_q.pop_front();
      read_one();
      checks++;
      if (DataOut !== w)
        $display("FAIL b2b_data%0d got %h want %h", i, DataOut, w);
      else passed++;
    end
  endtask

  task automatic test_random();
    int lenf;
    int n;
    bit relu;
    bit big;
    longint sum;
    logic [31:0] v;
    logic [31:0] w;
    do_reset();
    for (int g = 0; g < 30; g++) begin
      lenf = $urandom_range(0, 15);
      n = (lenf == 0) ? 16 : lenf;
      relu = 1'($urandom_range(0, 1));
      big = ($urandom_range(0, 2) == 0);
      ReluEnIn = relu;
      sum = 0;
      for (int i = 0; i < n; i++) begin
        v = big ? $urandom() : $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
        sum += longint'(signed'(v));
        beat(v, (i == 0) ? 4'(lenf) : 4'($urandom_range(0, 15)));
      end
      step();
      w = model(sum, relu);
      read_one();
      checks++;
      if (DataValidOut !== 1'b1 || DataOut !== w)
        $display("FAIL rand%0d len=%0d got %b/%h want 1/%h",
                 g, n, DataValidOut, DataOut, w);
      else passed++;
    end
    ReluEnIn = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ClearIn = 1'b0;
    ResultValidIn = 1'b0;
    ResultIn = '0;
    AccumLenIn = '0;
    ReluEnIn = 1'b0;
    ReadEnIn = 1'b0;
    test_reset();
    test_sum4();
    test_relu();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
